// File: rtl/data_pkg.sv
// Shared definitions for the SD data path sequencer and its helpers.
//   state_t    : sequencer FSM states
//   ERR_*      : error codes reported on oError_code
//   fifo_ready : FIFO room/occupancy test for one data block
package data_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SEND,
    WAIT,
    ACK,
    DONE,
    ERROR
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_CRC     = 3'd2;
  localparam logic [2:0] ERR_CONFIG  = 3'd3;
  localparam logic [2:0] ERR_ABORT   = 3'd4;

  // A write needs a whole block already buffered; a read needs room for one.
  function automatic logic fifo_ready(input logic        write,
                                      input logic [31:0] count,
                                      input logic [31:0] depth,
                                      input logic [31:0] words);
    if (write) return (count >= words);
    else       return (count <= (depth - words));
  endfunction

endpackage

// File: rtl/data_timeout_counter.sv
// Saturating cycle counter with a programmable expiry compare.
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   clear   in   synchronous clear (wins over enable)
//   enable  in   count one per cycle while high
//   limit   in   expiry value; 0 means never expire
//   expired out  count has reached a non-zero limit
module data_timeout_counter #(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      // Holds at all-ones instead of wrapping back below the limit.
      count <= count + 1'b1;
    end
  end

  assign expired = (limit != '0) && (count == limit);

endmodule

// File: rtl/data_block_sequencer.sv
// Sequences multi-block SD data transfers between data_control and data_send.
// A request is latched in IDLE, every block waits for FIFO room, is started
// with a one-cycle oSend, and is closed by iComplete/iCRC_ok from the PHY.
// Ports:
//   iClock, iReset                 clock, asynchronous active-low reset
//   iStart                         transfer request (ignored while busy)
//   iWriteRead, iMultipleData      direction, multi-block select
//   iBlocks                        block count when iMultipleData=1
//   iTimeout_enable, iTimeout_reg  timeout supervision and limit (0 = off)
//   iFIFO_count                    FIFO occupancy in words
//   iComplete, iCRC_ok             PHY block completion and CRC status
//   iAbort                         abort the running transfer
//   oSend, oAck, oDone             one-cycle pulses
//   oBusy                          transfer in progress
//   oError, oError_code            sticky error flag and cause
//   oBlocks_done                   blocks completed so far
module data_block_sequencer
  import data_pkg::*;
#(
  parameter int BLK_W         = 8,
  parameter int TO_W          = 16,
  parameter int CNT_W         = 6,
  parameter int FIFO_DEPTH    = 32,
  parameter int WORDS_PER_BLK = 16
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iStart,
  input  logic             iWriteRead,
  input  logic             iMultipleData,
  input  logic [BLK_W-1:0] iBlocks,
  input  logic             iTimeout_enable,
  input  logic [TO_W-1:0]  iTimeout_reg,
  input  logic [CNT_W-1:0] iFIFO_count,
  input  logic             iComplete,
  input  logic             iCRC_ok,
  input  logic             iAbort,
  output logic             oSend,
  output logic             oAck,
  output logic             oBusy,
  output logic             oDone,
  output logic             oError,
  output logic [2:0]       oError_code,
  output logic [BLK_W-1:0] oBlocks_done
);

  state_t           state;
  logic             write_read;
  logic [BLK_W-1:0] total;
  logic [TO_W-1:0]  to_limit;

  logic             to_run;
  logic             to_expired;
  logic             timed_out;
  logic             room;
  logic [BLK_W-1:0] start_total;
  logic [2:0]       fail_code;

  // The counter runs only in the two waiting states; any other state holds
  // it at zero, so each entry to CHECK or WAIT starts a fresh count.
  assign to_run    = (state == CHECK) || (state == WAIT);
  assign timed_out = iTimeout_enable && to_expired;

  data_timeout_counter #(
    .TO_W(TO_W)
  ) u_timeout (
    .clk    (iClock),
    .rst_n  (iReset),
    .clear  (!to_run),
    .enable (to_run),
    .limit  (to_limit),
    .expired(to_expired)
  );

  assign room        = fifo_ready(write_read, 32'(iFIFO_count),
                                  32'(FIFO_DEPTH), 32'(WORDS_PER_BLK));
  assign start_total = iMultipleData ? iBlocks : BLK_W'(1);

  // Failure priority: abort, then a completed block (good or bad CRC),
  // then timeout. A good completion therefore masks a same-cycle timeout.
  always_comb begin
    fail_code = ERR_NONE;
    case (state)
      CHECK: begin
        if (iAbort)         fail_code = ERR_ABORT;
        else if (timed_out) fail_code = ERR_TIMEOUT;
      end
      SEND, ACK: begin
        if (iAbort) fail_code = ERR_ABORT;
      end
      WAIT: begin
        if (iAbort)                      fail_code = ERR_ABORT;
        else if (iComplete && !iCRC_ok)  fail_code = ERR_CRC;
        else if (!iComplete && timed_out) fail_code = ERR_TIMEOUT;
      end
      default: fail_code = ERR_NONE;
    endcase
  end

  // Outputs are registered on the transition into the state they belong to,
  // so each pulse is visible for exactly the cycle spent in that state.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state        <= IDLE;
      write_read   <= 1'b0;
      total        <= '0;
      to_limit     <= '0;
      oSend        <= 1'b0;
      oAck         <= 1'b0;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oError       <= 1'b0;
      oError_code  <= ERR_NONE;
      oBlocks_done <= '0;
    end else begin
      oSend <= 1'b0;
      oAck  <= 1'b0;
      oDone <= 1'b0;
      if (fail_code != ERR_NONE) begin
        state       <= ERROR;
        oError      <= 1'b1;
        oError_code <= fail_code;
        oBusy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (iStart) begin
              write_read   <= iWriteRead;
              total        <= start_total;
              to_limit     <= iTimeout_reg;
              oBlocks_done <= '0;
              if (start_total == '0) begin
                state       <= ERROR;
                oError      <= 1'b1;
                oError_code <= ERR_CONFIG;
                oBusy       <= 1'b0;
              end else begin
                state       <= CHECK;
                oError      <= 1'b0;
                oError_code <= ERR_NONE;
                oBusy       <= 1'b1;
              end
            end
          end
          CHECK: begin
            if (room) begin
              state <= SEND;
              oSend <= 1'b1;
            end
          end
          SEND: state <= WAIT;
          WAIT: begin
            // A bad CRC was already routed to ERROR through fail_code.
            if (iComplete) begin
              state        <= ACK;
              oAck         <= 1'b1;
              oBlocks_done <= oBlocks_done + 1'b1;
            end
          end
          ACK: begin
            // oBlocks_done already holds the incremented count here.
            if (oBlocks_done == total) begin
              state <= DONE;
              oDone <= 1'b1;
              oBusy <= 1'b0;
            end else begin
              state <= CHECK;
            end
          end
          DONE:    state <= IDLE;
          ERROR:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_block_sequencer.sv
// Directed bench for data_block_sequencer. Expected oSend/oAck/oDone/error
// events are queued as stimulus is applied and consumed by a negedge monitor.
module tb_data_block_sequencer;

  localparam int BLK_W = 8;
  localparam int TO_W  = 16;
  localparam int CNT_W = 6;

  localparam int K_SEND = 1;
  localparam int K_ACK  = 2;
  localparam int K_DONE = 3;
  localparam int K_ERR  = 4;

  logic             iClock = 1'b0;
  logic             iReset = 1'b1;
  logic             iStart = 1'b0;
  logic             iWriteRead = 1'b0;
  logic             iMultipleData = 1'b0;
  logic [BLK_W-1:0] iBlocks = '0;
  logic             iTimeout_enable = 1'b0;
  logic [TO_W-1:0]  iTimeout_reg = '0;
  logic [CNT_W-1:0] iFIFO_count = '0;
  logic             iComplete = 1'b0;
  logic             iCRC_ok = 1'b0;
  logic             iAbort = 1'b0;
  logic             oSend, oAck, oBusy, oDone, oError;
  logic [2:0]       oError_code;
  logic [BLK_W-1:0] oBlocks_done;

  data_block_sequencer #(
    .BLK_W(BLK_W), .TO_W(TO_W), .CNT_W(CNT_W),
    .FIFO_DEPTH(32), .WORDS_PER_BLK(16)
  ) dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart),
    .iWriteRead(iWriteRead), .iMultipleData(iMultipleData),
    .iBlocks(iBlocks), .iTimeout_enable(iTimeout_enable),
    .iTimeout_reg(iTimeout_reg), .iFIFO_count(iFIFO_count),
    .iComplete(iComplete), .iCRC_ok(iCRC_ok), .iAbort(iAbort),
    .oSend(oSend), .oAck(oAck), .oBusy(oBusy), .oDone(oDone),
    .oError(oError), .oError_code(oError_code),
    .oBlocks_done(oBlocks_done)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t sb[$];
  int  tests = 0;
  int  fails = 0;

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input string tag, input int kind, input int val);
    ev_t e;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL sb_%s: observed unexpected event val %0d, expected no event", tag, val);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (e.kind == kind && e.val == val) else begin
        fails++;
        $error("FAIL sb_%s: observed kind %0d val %0d expected kind %0d val %0d",
               tag, kind, val, e.kind, e.val);
      end
    end
  endtask

  // Event monitor: errors are recognised on a rise of oError or on a change
  // of code while it stays high (bad config straight after an earlier error).
  logic       err_q  = 1'b0;
  logic [2:0] code_q = 3'd0;
  always @(negedge iClock) begin
    if (iReset) begin
      if (oSend) sb_pop("send", K_SEND, int'(oBlocks_done));
      if (oAck)  sb_pop("ack",  K_ACK,  int'(oBlocks_done));
      if (oDone) sb_pop("done", K_DONE, int'(oBlocks_done));
      if (oError && (!err_q || oError_code != code_q))
        sb_pop("error", K_ERR, int'(oError_code));
    end
    err_q  = oError;
    code_q = oError_code;
  end

  task automatic start_xfer(input logic wr, input logic mult, input int blocks);
    iWriteRead    = wr;
    iMultipleData = mult;
    iBlocks       = BLK_W'(blocks);
    iStart        = 1'b1;
    tick();
    iStart        = 1'b0;
  endtask

  task automatic wait_send(input string tag);
    int n = 0;
    while (oSend !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_send_seen"}, oSend, 1);
  endtask

  task automatic pulse_complete(input logic crc);
    iComplete = 1'b1;
    iCRC_ok   = crc;
    tick();
    iComplete = 1'b0;
    iCRC_ok   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (oBusy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, oBusy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish within 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    // Reset values
    #2 iReset = 1'b0;
    tick(); tick();
    check("rst_busy", oBusy, 0);
    check("rst_send", oSend, 0);
    check("rst_error", oError, 0);
    check("rst_code", oError_code, 0);
    check("rst_blocks", oBlocks_done, 0);
    iReset = 1'b1;
    tick();

    // Write, single block: oSend two cycles after iStart
    iFIFO_count = 6'd16;
    push(K_SEND, 0);
    start_xfer(1'b1, 1'b0, 5);
    check("wr1_busy", oBusy, 1);
    check("wr1_nosend_n1", oSend, 0);
    tick();
    check("wr1_send_n2", oSend, 1);
    tick();
    push(K_ACK, 1);
    push(K_DONE, 1);
    pulse_complete(1'b1);
    check("wr1_ack", oAck, 1);
    tick();
    check("wr1_done", oDone, 1);
    wait_idle("wr1");
    check("wr1_blocks", oBlocks_done, 1);
    check("wr1_error", oError, 0);
    tick();

    // Read, 3 blocks, held back by FIFO level; stray start/complete ignored
    iFIFO_count = 6'd20;
    push(K_SEND, 0);
    start_xfer(1'b0, 1'b1, 3);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rd_hold_nosend", oSend, 0);
      iStart = 1'b0; iComplete = 1'b0; iCRC_ok = 1'b0;
      iWriteRead = 1'b0; iMultipleData = 1'b1; iBlocks = 8'd3;
      if (i == 1) begin
        iStart = 1'b1; iWriteRead = 1'b1; iMultipleData = 1'b0; iBlocks = 8'd1;
      end
      if (i == 3) begin
        iComplete = 1'b1; iCRC_ok = 1'b1;
      end
    end
    check("rd_hold_busy", oBusy, 1);
    check("rd_hold_blocks", oBlocks_done, 0);
    iFIFO_count = 6'd16;
    for (int b = 0; b < 3; b++) begin
      wait_send("rd");
      tick();
      push(K_ACK, b + 1);
      if (b == 2) push(K_DONE, 3);
      else        push(K_SEND, b + 1);
      pulse_complete(1'b1);
    end
    wait_idle("rd");
    check("rd_blocks", oBlocks_done, 3);
    check("rd_error", oError, 0);
    tick();

    // Timeout in WAIT
    iTimeout_enable = 1'b1;
    iTimeout_reg    = 16'd10;
    push(K_SEND, 0);
    push(K_ERR, 1);
    start_xfer(1'b1, 1'b0, 1);
    wait_send("to");
    lat = 0;
    while (oError !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    tests++;
    assert (lat >= 10 && lat <= 13) else begin
      fails++;
      $error("FAIL to_latency: observed %0d cycles expected 10..13", lat);
    end
    check("to_error", oError, 1);
    check("to_code", oError_code, 1);
    check("to_busy", oBusy, 0);
    iTimeout_enable = 1'b0;
    tick();

    // CRC failure on block 2 of 4
    push(K_SEND, 0);
    start_xfer(1'b1, 1'b1, 4);
    check("crc_err_cleared", oError, 0);
    check("crc_code_cleared", oError_code, 0);
    wait_send("crc1");
    tick();
    push(K_ACK, 1);
    push(K_SEND, 1);
    pulse_complete(1'b1);
    wait_send("crc2");
    tick();
    push(K_ERR, 2);
    pulse_complete(1'b0);
    check("crc_error", oError, 1);
    check("crc_code", oError_code, 2);
    check("crc_blocks", oBlocks_done, 1);
    check("crc_busy", oBusy, 0);
    tick(); tick(); tick();

    // Abort in WAIT, then abort in IDLE has no effect
    push(K_SEND, 0);
    push(K_ERR, 4);
    start_xfer(1'b1, 1'b0, 1);
    wait_send("abt");
    tick();
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    check("abt_error", oError, 1);
    check("abt_code", oError_code, 4);
    check("abt_busy", oBusy, 0);
    check("abt_blocks", oBlocks_done, 0);
    tick();
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    tick();
    check("abt_idle_busy", oBusy, 0);
    check("abt_idle_code", oError_code, 4);

    // Bad config: multi-block with zero blocks
    push(K_ERR, 3);
    start_xfer(1'b1, 1'b1, 0);
    check("cfg_error", oError, 1);
    check("cfg_code", oError_code, 3);
    check("cfg_busy", oBusy, 0);
    tick(); tick(); tick();
    check("cfg_still_idle", oBusy, 0);

    // Asynchronous reset mid-transfer
    push(K_SEND, 0);
    start_xfer(1'b1, 1'b0, 1);
    wait_send("rst");
    tick();
    check("rst_mid_busy_before", oBusy, 1);
    #2 iReset = 1'b0;
    #1;
    check("rst_mid_busy", oBusy, 0);
    check("rst_mid_error", oError, 0);
    check("rst_mid_code", oError_code, 0);
    check("rst_mid_blocks", oBlocks_done, 0);
    check("rst_mid_send", oSend, 0);
    check("rst_mid_ack", oAck, 0);
    check("rst_mid_done", oDone, 0);
    tick(); tick();
    iReset = 1'b1;
    tick(); tick(); tick();
    check("rst_after_busy", oBusy, 0);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
